fft16_radix4_core: RTL and testbench
====================================

# fft16_radix4_core

Datapath core of the 16-point radix-4 decimation-in-frequency pipelined FFT. It sits between the input signal-select stage and the output collector:
- The signal-select stage supplies four time-aligned complex taps and a 2-bit phase.
- The core performs the stage-1 radix-4 butterfly with twiddle multiplication.
- It transposes the results through a 4x4 commutator.
- It performs the stage-2 radix-4 butterfly, emitting four frequency bins per cycle.

## Interface
Parameters:
- DW, 32, data word width (signed two's complement).
- TW, 16, twiddle width (signed Q2.14).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- q  in  2  stage-1 phase n (0..3) from the signal-select counter.
- x0_re, x0_im  in  DW each  tap x[n] (oldest sample, 12-cycle delay).
- x1_re, x1_im  in  DW each  tap x[n+4].
- x2_re, x2_im  in  DW each  tap x[n+8].
- x3_re, x3_im  in  DW each  tap x[n+12] (newest sample).
- y0_re..y3_re, y0_im..y3_im  out  DW each  output bins; yj = X[k+4j].
- k_out  out  2  output phase k (0..3).

## Operation
Stage-1 butterfly (combinational). With a,b,c,d = x0..x3:
- B0 = a+b+c+d
- B1re = (ar-cr)+(bi-di); B1im = (ai-ci)-(br-dr)
- B2 = (a+c)-(b+d)
- B3re = (ar-cr)-(bi-di); B3im = (ai-ci)+(br-dr)

Twiddle multiplication:
- Output Bk is multiplied by W16^m, with m = n·k and n = q.
- W = C - jS. Table of (C, S) per m:
  - m=0: (16384, 0)
  - m=1: (15137, 6270)
  - m=2: (11585, 11585)
  - m=3: (6270, 15137)
  - m=4: (0, 16384)
  - m=6: (-11585, 11585)
  - m=9: (-15137, -6270)
- Tre = (Bre·C + Bim·S) >>> 14; Tim = (Bim·C - Bre·S) >>> 14.
- Products and sums are formed at 49 bits, shifted arithmetically (floor), then the low DW bits are kept.

Commutator (4x4 transpose):
- Two banks of 4x4 complex words.
- On every rising edge, T0..T3 are written into row q of the write bank.
- On the edge that writes q=3, the write/read bank roles swap.
- Read column k_out from the read bank: element (row r, col k) = Tk from phase r.

Stage-2 butterfly:
- Same formulas as stage 1, with a..d = rows 0..3 of column k_out.
- No twiddle; outputs drive y0..y3 combinationally.

Arithmetic rules:
- All adds and subtracts wrap modulo 2^DW; no saturation, no scaling.
- The caller keeps |input| < 2^27 to avoid overflow.

## Timing
- k_out is a register: on each edge, k_out <= (q+1) mod 4.
- The bank toggle register and all bank words are registers.
- Reset (asynchronous, while reset=0) forces:
  - all bank words to 0
  - bank select to 0
  - k_out to 0
  - therefore y0..y3 = 0 immediately.
- Release of reset takes effect at the next rising edge with reset=1.
- Latency: a frame whose phases q=0..3 occur in cycles c..c+3 yields k_out=0..3 in cycles c+4..c+7. In those cycles, yj = X[k+4j] of that frame.
- Stage-1 and stage-2 paths are purely combinational. The only state is the commutator banks, the bank select and k_out.
- q is expected to count 0,1,2,3 continuously.
  - A non-sequential q writes whichever row q names.
  - The bank swaps only when q=3 is written.
- Assertion of reset mid-frame discards both banks. The first valid output frame is the first complete q=0..3 sequence after release.

## Test plan
- Reset: hold reset=0 with arbitrary inputs -> y*=0 and k_out=0. Release, then drive q=0,1,2,3 -> y*=0 until the first full frame completes.
- Impulse: x[0]=1000 (re and im), all other samples 0 -> every bin over k_out=0..3 is re=1000, im=1000.
- DC: x[n]=100 real, 0 imaginary, for all n -> X[0]=1600 (y0 at k_out=0); all other bins 0.
- Shifted impulse: x[4]=1000 real -> X[k]=1000·(-j)^k. Expect X[0]=1000, X[1]=(0,-1000), X[2]=-1000, X[3]=(0,1000), repeating over the 16 bins.
- Twiddle check: x[1]=16384 real -> X[1] = 16384·W16^1 ≈ (15137, -6270) within ±2 LSB of truncation. X[0] = (16384, 0).
- Back-to-back frames: the impulse frame followed immediately by the DC frame -> the second frame's bins appear exactly 4 cycles after the first frame's, with no corruption across the bank swap.

Source files
------------

// File: rtl/fft16_radix4_core_if.sv
// rtl/fft16_radix4_core_if.sv - tap/phase inputs and bin/phase outputs of the 16-point FFT core
interface fft16_radix4_core_if #(
    parameter int DW = 32
);
    logic [1:0]    q;
    logic [DW-1:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im;
    logic [DW-1:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im;
    logic [1:0]    k_out;

    modport master (
        output q,
        output x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
        input  y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im,
        input  k_out
    );

    modport slave (
        input  q,
        input  x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
        output y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im,
        output k_out
    );
endinterface

// File: rtl/fft16_radix4_core.sv
// rtl/fft16_radix4_core.sv - radix-4 DIF 16-point FFT core: butterfly+twiddle, 4x4 commutator, butterfly
module fft16_radix4_core #(
    parameter int DW = 32,
    parameter int TW = 16
) (
    input  logic               clk,
    input  logic               reset,
    fft16_radix4_core_if.slave bus
);
    localparam int PW = DW + TW + 1;

    typedef logic [3:0][DW-1:0] vec4_t;

    function automatic void bfly(input vec4_t xr, input vec4_t xi, output vec4_t yr, output vec4_t yi);
        logic [DW-1:0] acr, aci, bdr, bdi;
        acr   = xr[0] - xr[2];
        aci   = xi[0] - xi[2];
        bdr   = xr[1] - xr[3];
        bdi   = xi[1] - xi[3];
        yr[0] = xr[0] + xr[1] + xr[2] + xr[3];
        yi[0] = xi[0] + xi[1] + xi[2] + xi[3];
        yr[1] = acr + bdi;
        yi[1] = aci - bdr;
        yr[2] = (xr[0] + xr[2]) - (xr[1] + xr[3]);
        yi[2] = (xi[0] + xi[2]) - (xi[1] + xi[3]);
        yr[3] = acr - bdi;
        yi[3] = aci + bdr;
    endfunction

    // Returns {C, S} of W16^m = C - jS in Q2.14; only m in {0,1,2,3,4,6,9} is reachable.
    function automatic logic [2*TW-1:0] twiddle(input logic [3:0] m);
        logic [TW-1:0] c, s;
        case (m)
            4'd1:    begin c = TW'(15137);  s = TW'(6270);   end
            4'd2:    begin c = TW'(11585);  s = TW'(11585);  end
            4'd3:    begin c = TW'(6270);   s = TW'(15137);  end
            4'd4:    begin c = TW'(0);      s = TW'(16384);  end
            4'd6:    begin c = TW'(-11585); s = TW'(11585);  end
            4'd9:    begin c = TW'(-15137); s = TW'(-6270);  end
            default: begin c = TW'(16384);  s = TW'(0);      end
        endcase
        return {c, s};
    endfunction

    vec4_t                x_re, x_im, b_re, b_im, t_re, t_im;
    vec4_t                c_re, c_im, y_re, y_im;
    logic [3:0]           m    [4];
    logic [2*TW-1:0]      cs   [4];
    logic signed [PW-1:0] p_re [4];
    logic signed [PW-1:0] p_im [4];

    logic [DW-1:0] bank_re_q [2][4][4];
    logic [DW-1:0] bank_im_q [2][4][4];
    logic [DW-1:0] bank_re_d [2][4][4];
    logic [DW-1:0] bank_im_d [2][4][4];
    logic          bank_sel_q, bank_sel_d;
    logic [1:0]    k_out_q, k_out_d;

    always_comb begin
        x_re = {bus.x3_re, bus.x2_re, bus.x1_re, bus.x0_re};
        x_im = {bus.x3_im, bus.x2_im, bus.x1_im, bus.x0_im};
        bfly(x_re, x_im, b_re, b_im);
        for (int k = 0; k < 4; k++) begin
            m[k]    = 4'(bus.q) * 4'(k);
            cs[k]   = twiddle(m[k]);
            p_re[k] = PW'($signed(b_re[k])) * PW'($signed(cs[k][2*TW-1:TW]))
                    + PW'($signed(b_im[k])) * PW'($signed(cs[k][TW-1:0]));
            p_im[k] = PW'($signed(b_im[k])) * PW'($signed(cs[k][2*TW-1:TW]))
                    - PW'($signed(b_re[k])) * PW'($signed(cs[k][TW-1:0]));
            t_re[k] = DW'(p_re[k] >>> (TW - 2));
            t_im[k] = DW'(p_im[k] >>> (TW - 2));
        end
    end

    // Row q of the write bank takes this phase's twiddled outputs; writing row 3 completes the frame.
    always_comb begin
        bank_re_d = bank_re_q;
        bank_im_d = bank_im_q;
        for (int j = 0; j < 4; j++) begin
            bank_re_d[bank_sel_q][bus.q][j] = t_re[j];
            bank_im_d[bank_sel_q][bus.q][j] = t_im[j];
        end
        bank_sel_d = (bus.q == 2'd3) ? ~bank_sel_q : bank_sel_q;
        k_out_d    = bus.q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        bank_re_q[b][r][c] <= '0;
                        bank_im_q[b][r][c] <= '0;
                    end
                end
            end
            bank_sel_q <= 1'b0;
            k_out_q    <= 2'd0;
        end else begin
            bank_re_q  <= bank_re_d;
            bank_im_q  <= bank_im_d;
            bank_sel_q <= bank_sel_d;
            k_out_q    <= k_out_d;
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            c_re[r] = bank_re_q[~bank_sel_q][r][k_out_q];
            c_im[r] = bank_im_q[~bank_sel_q][r][k_out_q];
        end
        bfly(c_re, c_im, y_re, y_im);
    end

    assign bus.y0_re = y_re[0];
    assign bus.y0_im = y_im[0];
    assign bus.y1_re = y_re[1];
    assign bus.y1_im = y_im[1];
    assign bus.y2_re = y_re[2];
    assign bus.y2_im = y_im[2];
    assign bus.y3_re = y_re[3];
    assign bus.y3_im = y_im[3];
    assign bus.k_out = k_out_q;
endmodule

// File: tb/tb_fft16_radix4_core.sv
// tb/tb_fft16_radix4_core.sv - directed-vector bench for the 16-point radix-4 FFT core
module tb_fft16_radix4_core;
    localparam int DW = 32;
    localparam int NF = 6;

    logic clk;
    logic reset;

    fft16_radix4_core_if #(.DW(DW)) bus ();

    fft16_radix4_core #(.DW(DW), .TW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    int in_re [NF][16];
    int in_im [NF][16];
    int ex_re [NF][16];
    int ex_im [NF][16];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic logic [DW-1:0] y_re(input int j);
        case (j)
            0:       return bus.y0_re;
            1:       return bus.y1_re;
            2:       return bus.y2_re;
            default: return bus.y3_re;
        endcase
    endfunction

    function automatic logic [DW-1:0] y_im(input int j);
        case (j)
            0:       return bus.y0_im;
            1:       return bus.y1_im;
            2:       return bus.y2_im;
            default: return bus.y3_im;
        endcase
    endfunction

    task automatic drive_taps(input int f, input int n, input bit zero);
        bus.q     = 2'(n);
        bus.x0_re = zero ? 0 : in_re[f][n];
        bus.x0_im = zero ? 0 : in_im[f][n];
        bus.x1_re = zero ? 0 : in_re[f][n+4];
        bus.x1_im = zero ? 0 : in_im[f][n+4];
        bus.x2_re = zero ? 0 : in_re[f][n+8];
        bus.x2_im = zero ? 0 : in_im[f][n+8];
        bus.x3_re = zero ? 0 : in_re[f][n+12];
        bus.x3_im = zero ? 0 : in_im[f][n+12];
    endtask

    task automatic run_frames(input int f0, input int f1);
        int er, ei;
        for (int f = f0; f <= f1 + 1; f++) begin
            for (int n = 0; n < 4; n++) begin
                drive_taps((f <= f1) ? f : 0, n, f > f1);
                @(negedge clk);
                check_val($sformatf("k_out f%0d n%0d", f, n), 32'(bus.k_out), n);
                for (int j = 0; j < 4; j++) begin
                    er = 0;
                    ei = 0;
                    if (f > f0) begin
                        er = ex_re[f-1][n+4*j];
                        ei = ex_im[f-1][n+4*j];
                    end
                    check_val($sformatf("X[%0d].re after f%0d", n + 4*j, f - 1), y_re(j), er);
                    check_val($sformatf("X[%0d].im after f%0d", n + 4*j, f - 1), y_im(j), ei);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, " k_out"}, 32'(bus.k_out), 0);
        for (int j = 0; j < 4; j++) begin
            check_val($sformatf("%s y%0d.re", tag, j), y_re(j), 0);
            check_val($sformatf("%s y%0d.im", tag, j), y_im(j), 0);
        end
    endtask

    // Single-sample frames x[r]=16384: X[k+4j] = T_k * (-j)^(r*j), T_k = 16384*W16^(r*k).
    int t_re [3][4] = '{'{16384, 15137, 11585, 6270}, '{16384, 6270, -11585, -15137}, '{16384, 11585, 0, -11585}};
    int t_im [3][4] = '{'{0, -6270, -11585, -15137}, '{0, -15137, -11585, 6270}, '{0, -11585, -16384, -11585}};
    int t_row [3]   = '{1, 3, 2};

    initial begin
        int tr, ti;
        n_cmp = 0;
        n_bad = 0;
        clk   = 1'b0;
        reset = 1'b0;

        for (int f = 0; f < NF; f++) begin
            for (int b = 0; b < 16; b++) begin
                in_re[f][b] = 0; in_im[f][b] = 0; ex_re[f][b] = 0; ex_im[f][b] = 0;
            end
        end
        in_re[0][0] = 1000;
        in_im[0][0] = 1000;
        for (int b = 0; b < 16; b++) begin
            ex_re[0][b] = 1000;
            ex_im[0][b] = 1000;
            in_re[1][b] = 100;
        end
        ex_re[1][0] = 1600;
        in_re[2][4] = 1000;
        for (int b = 0; b < 16; b++) begin
            case (b % 4)
                0: ex_re[2][b] = 1000;
                1: ex_im[2][b] = -1000;
                2: ex_re[2][b] = -1000;
                default: ex_im[2][b] = 1000;
            endcase
        end
        for (int t = 0; t < 3; t++) begin
            in_re[3+t][t_row[t]] = 16384;
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) begin
                    tr = t_re[t][k];
                    ti = t_im[t][k];
                    case ((t_row[t] * j) % 4)
                        0:       begin ex_re[3+t][k+4*j] = tr;  ex_im[3+t][k+4*j] = ti;  end
                        1:       begin ex_re[3+t][k+4*j] = ti;  ex_im[3+t][k+4*j] = -tr; end
                        2:       begin ex_re[3+t][k+4*j] = -tr; ex_im[3+t][k+4*j] = -ti; end
                        default: begin ex_re[3+t][k+4*j] = -ti; ex_im[3+t][k+4*j] = tr;  end
                    endcase
                end
            end
        end

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.q     = 2'($urandom_range(0, 3));
            bus.x0_re = $urandom(); bus.x0_im = $urandom();
            bus.x1_re = $urandom(); bus.x1_im = $urandom();
            bus.x2_re = $urandom(); bus.x2_im = $urandom();
            bus.x3_re = $urandom(); bus.x3_im = $urandom();
            #3;
            check_zero($sformatf("reset%0d", i));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_frames(0, NF - 1);

        drive_taps(2, 0, 1'b0);
        @(posedge clk);
        #1;
        drive_taps(2, 1, 1'b0);
        @(posedge clk);
        #1;
        drive_taps(2, 2, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("midframe_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_frames(3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
